// File: rtl/mmu_walk.sv
// Single-level MMU: 4 spaces x NMMU pages, same-cycle lookup, fault latch and control registers.
// Define MMU_HW_WALK_EN to build the hardware page-table walker; otherwise every miss is a software-refill fault.
module mmu_walk #(
  parameter int RV   = 16,
  parameter int VA   = RV,
  parameter int PA   = RV,
  parameter int NMMU = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic                is_pc,
  input  logic                is_write,
  input  logic                supmode,
  input  logic                mmu_i_proxy,
  input  logic                mmu_d_proxy,
  input  logic                mmu_enable,
  input  logic [VA-1:RV/16]   addrv,
  output logic [PA-1:RV/16]   addrp,
  output logic                ready,
  output logic                mmu_miss_fault,
  output logic                mmu_prot_fault,
  input  logic                reg_write,
  input  logic [1:0]          reg_sel,
  input  logic [RV-1:0]       reg_data,
  output logic [RV-1:0]       reg_read,
  output logic                wreq,
  output logic [PA-1:RV/16]   waddr,
  input  logic                wack,
  input  logic [RV-1:0]       wdata
);
  localparam int LSB  = RV / 16;
  localparam int PGW  = $clog2(NMMU);
  localparam int OFFW = VA - PGW;
  localparam int VPB  = PA - OFFW;
  localparam int IW   = PGW + 2;
  localparam int NENT = 4 * NMMU;
  localparam int PAW  = PA - LSB;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, FILL = 2'd2} state_t;

  logic [VPB-1:0]  r_vtop [NENT];
  logic [NENT-1:0] r_valid;
  logic [NENT-1:0] r_wr;
  logic [RV-1:0]   r_ptbr;
  logic [PGW-1:0]  r_flt_addr;
  logic            r_flt_valid, r_flt_write, r_flt_ins, r_flt_sup;

  logic [IW-1:0]   w_idx, w_src_idx, w_fill_idx, w_flt_idx;
  logic [RV-1:0]   w_fill_pte;
  logic [PAW-1:0]  w_addrp;
  logic            w_ready, w_miss, w_prot, w_src_write, w_fill, w_start, w_walk_en, w_reg_ent;
  logic            w_unused;
  state_t          w_state, w_next;

  assign w_idx     = {is_pc | (supmode & mmu_i_proxy), supmode & ~mmu_d_proxy, addrv[VA-1:OFFW]};
  assign w_flt_idx = {r_flt_ins, r_flt_sup, r_flt_addr};
  assign w_reg_ent = reg_write & (reg_sel == 2'd0) & reg_data[0];

`ifdef MMU_HW_WALK_EN
  state_t          r_state;
  logic            r_walk_en, r_walk_write;
  logic [RV-1:0]   r_pte;
  logic [IW-1:0]   r_walk_idx;
  logic [PAW-1:0]  r_waddr;

  assign w_state   = r_state;
  assign w_walk_en = r_walk_en;
  assign wreq      = (r_state == FETCH);
  assign waddr     = r_waddr;
  assign w_unused  = ^{reg_data, r_pte};

  // Walker state and the request context captured when a walk starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_walk_en    <= 1'b0;
      r_walk_write <= 1'b0;
      r_pte        <= {RV{1'b0}};
      r_walk_idx   <= {IW{1'b0}};
      r_waddr      <= {PAW{1'b0}};
    end else begin
      r_state <= w_next;
      if (reg_write && reg_sel == 2'd2) r_walk_en <= reg_data[1];
      if (w_start) begin
        r_walk_idx   <= w_idx;
        r_walk_write <= is_write;
        r_waddr      <= PAW'(r_ptbr) + PAW'(w_idx);
      end
      if (r_state == FETCH && wack) r_pte <= wdata;
    end
  end
`else
  assign w_state   = IDLE;
  assign w_walk_en = 1'b0;
  assign wreq      = 1'b0;
  assign waddr     = {PAW{1'b0}};
  assign w_unused  = ^{reg_data, wack, wdata, w_next, w_start};
`endif

  // Lookup, fault decision and walker next state
  always_comb begin
    w_ready     = 1'b0;
    w_miss      = 1'b0;
    w_prot      = 1'b0;
    w_start     = 1'b0;
    w_fill      = 1'b0;
    w_next      = w_state;
    w_src_idx   = w_idx;
    w_src_write = is_write;
    w_fill_idx  = w_idx;
    w_fill_pte  = {RV{1'b0}};
    w_addrp     = {r_vtop[w_idx], addrv[OFFW-1:LSB]};
    case (w_state)
      IDLE: begin
        if (!mmu_enable) begin
          w_ready = req;
          w_addrp = PAW'(addrv);
        end else if (!req) begin
          w_ready = 1'b0;
        end else if (r_valid[w_idx]) begin
          w_ready = 1'b1;
          w_prot  = is_write & ~r_wr[w_idx];
        end else if (w_walk_en) begin
          w_start = 1'b1;
          w_next  = FETCH;
        end else begin
          w_ready = 1'b1;
          w_miss  = 1'b1;
        end
      end
`ifdef MMU_HW_WALK_EN
      FETCH: begin
        if (wack) w_next = FILL;
        else      w_next = FETCH;
      end
      // Valid PTE refills the table and lets IDLE re-run the lookup
      FILL: begin
        w_next      = IDLE;
        w_src_idx   = r_walk_idx;
        w_src_write = r_walk_write;
        w_fill_idx  = r_walk_idx;
        w_fill_pte  = r_pte;
        if (r_pte[1]) begin
          w_fill = 1'b1;
        end else begin
          w_ready = 1'b1;
          w_miss  = 1'b1;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  assign ready          = w_ready & ~reset;
  assign mmu_miss_fault = w_ready & w_miss & ~reset;
  assign mmu_prot_fault = w_ready & w_prot & ~reset;
  assign addrp          = w_addrp;

  // Control registers; a fault latch overrides a same-cycle field write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptbr      <= {RV{1'b0}};
      r_flt_addr  <= {PGW{1'b0}};
      r_flt_valid <= 1'b0;
      r_flt_write <= 1'b0;
      r_flt_ins   <= 1'b0;
      r_flt_sup   <= 1'b0;
    end else begin
      if (reg_write && reg_sel == 2'd1) r_ptbr <= reg_data;
      if (reg_write && reg_sel == 2'd0 && !reg_data[0]) begin
        r_flt_addr  <= reg_data[RV-1:RV-PGW];
        r_flt_ins   <= reg_data[4];
        r_flt_sup   <= reg_data[3];
        r_flt_write <= reg_data[2];
        r_flt_valid <= reg_data[1];
      end
      if (w_ready && (w_miss || w_prot)) begin
        r_flt_addr  <= w_src_idx[PGW-1:0];
        r_flt_ins   <= w_src_idx[IW-1];
        r_flt_sup   <= w_src_idx[IW-2];
        r_flt_write <= w_src_write;
        r_flt_valid <= w_prot;
      end
    end
  end

  // Valid bits; refill is applied last so it wins over register writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= {NENT{1'b0}};
    end else begin
      if (reg_write && reg_sel == 2'd3 && reg_data[0]) r_valid <= {NENT{1'b0}};
      if (w_reg_ent) r_valid[w_flt_idx] <= reg_data[1];
      if (w_fill)    r_valid[w_fill_idx] <= 1'b1;
    end
  end

  // Translation payload, meaningful only where the valid bit is set
  always_ff @(posedge clk) begin
    if (w_reg_ent) begin
      r_vtop[w_flt_idx] <= reg_data[RV-1:RV-VPB];
      r_wr[w_flt_idx]   <= reg_data[2];
    end
    if (w_fill) begin
      r_vtop[w_fill_idx] <= w_fill_pte[RV-1:RV-VPB];
      r_wr[w_fill_idx]   <= w_fill_pte[2];
    end
  end

  // Control-register read mux
  always_comb begin
    case (reg_sel)
      2'd0:    reg_read = {r_flt_addr, {(RV-PGW-5){1'b0}}, r_flt_ins, r_flt_sup, r_flt_write, r_flt_valid, 1'b0};
      2'd1:    reg_read = r_ptbr;
      default: reg_read = {RV{1'b0}};
    endcase
  end
endmodule
